// File: rtl/rvc_asap_pkg.sv
// rvc_asap_pkg: shared arbiter state encoding and default lock-hold limit.
package rvc_asap_pkg;
   typedef enum logic {ARB_RR, ARB_LOCK} t_arb_state;
   localparam int unsigned HOLD_MAX_DEF = 8;
endpackage

// File: rtl/rvc_asap_dmem_arb.sv
// rvc_asap_dmem_arb: two-requester data-memory arbiter, round-robin with a bounded
// burst lock for requester 1 and a one-cycle tagged read return.
module rvc_asap_dmem_arb
   import rvc_asap_pkg::*;
#(
   parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
   input  logic        Clock,
   input  logic        Rst,
   input  logic        Req0,
   input  logic        Req1,
   input  logic        WrEn0,
   input  logic        WrEn1,
   input  logic [3:0]  ByteEn0,
   input  logic [3:0]  ByteEn1,
   input  logic [31:0] Addr0,
   input  logic [31:0] Addr1,
   input  logic [31:0] WrData0,
   input  logic [31:0] WrData1,
   input  logic        Lock1,
   output logic        Gnt0,
   output logic        Gnt1,
   output logic        Stall0,
   output logic        RdValid0,
   output logic        RdValid1,
   output logic [31:0] RdData,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWrData,
   output logic [3:0]  MemByteEn,
   output logic        MemWrEn,
   output logic        MemRdEn,
   input  logic [31:0] MemRdData
);
   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

   t_arb_state state_q, state_d;
   logic       last_gnt_q, last_gnt_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       rd_v0_q, rd_v0_d, rd_v1_q, rd_v1_d;
   logic       lock, force_rel, gv, wr_sel;

   always_comb begin
      lock       = state_q == ARB_LOCK;
      force_rel  = lock & Req0 & (hold_cnt_q == HOLD_LIM);
      Gnt1       = Req1 & (lock ? ~force_rel : (~Req0 | ~last_gnt_q));
      Gnt0       = Req0 & ~Gnt1;
      Stall0     = Req0 & ~Gnt0;
      // memory side is silenced during reset even though grants stay combinational
      gv         = (Gnt0 | Gnt1) & Rst;
      wr_sel     = Gnt1 ? WrEn1 : WrEn0;
      MemAddr    = gv ? (Gnt1 ? Addr1 : Addr0) : '0;
      MemWrData  = gv ? (Gnt1 ? WrData1 : WrData0) : '0;
      MemByteEn  = gv ? (Gnt1 ? ByteEn1 : ByteEn0) : '0;
      MemWrEn    = gv & wr_sel;
      MemRdEn    = gv & ~wr_sel;
      RdValid0   = rd_v0_q;
      RdValid1   = rd_v1_q;
      RdData     = (rd_v0_q | rd_v1_q) ? MemRdData : '0;
      state_d    = lock ? ((~Lock1 | ~Req1 | force_rel) ? ARB_RR : ARB_LOCK)
                        : ((Gnt1 & Lock1) ? ARB_LOCK : ARB_RR);
      hold_cnt_d = ((lock & state_d == ARB_RR) | Gnt0) ? 8'd0
                 : (lock & Gnt1 & Req0 & hold_cnt_q != 8'hFF) ? hold_cnt_q + 8'd1
                 : hold_cnt_q;
      last_gnt_d = Gnt1 ? 1'b1 : Gnt0 ? 1'b0 : last_gnt_q;
      rd_v0_d    = Gnt0 & ~WrEn0;
      rd_v1_d    = Gnt1 & ~WrEn1;
   end

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         state_q    <= ARB_RR;
         last_gnt_q <= 1'b1;
         hold_cnt_q <= '0;
         rd_v0_q    <= 1'b0;
         rd_v1_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         hold_cnt_q <= hold_cnt_d;
         rd_v0_q    <= rd_v0_d;
         rd_v1_q    <= rd_v1_d;
      end
   end
endmodule

// File: doc/rvc_asap_dmem_arb.md
RVC_ASAP_DMEM_ARB -- requirements
Module: rvc_asap_dmem_arb

Interface
REQ-001 Parameter: HOLD_MAX, 8, max consecutive locked grants to requester 1 while requester 0 is waiting (range 1..255).
REQ-002 Clock  in  1  single clock; all state updates on rising edge.
REQ-003 Rst  in  1  reset, asynchronous, active-low.
REQ-004 Req0 / Req1  in  1  access request, requester 0 = core D_MEM port, requester 1 = loader/debug port.
REQ-005 WrEn0 / WrEn1  in  1  1 = write, 0 = read.
REQ-006 ByteEn0 / ByteEn1  in  4  byte enables.
REQ-007 Addr0 / Addr1  in  32  byte address.
REQ-008 WrData0 / WrData1  in  32  write data.
REQ-009 Lock1  in  1  requester 1 asks to keep its grant (burst).
REQ-010 Gnt0 / Gnt1  out  1  grant, same cycle as request.
REQ-011 Stall0  out  1  core stall = Req0 & ~Gnt0.
REQ-012 RdValid0 / RdValid1  out  1  read data valid for that requester.
REQ-013 RdData  out  32  read data, shared by both requesters, qualified by RdValid0/RdValid1.
REQ-014 MemAddr / MemWrData  out  32  to single-port memory.
REQ-015 MemByteEn  out  4  to memory.
REQ-016 MemWrEn / MemRdEn  out  1  memory write/read strobes.
REQ-017 MemRdData  in  32  memory read data, valid 1 cycle after MemRdEn.

Function
REQ-018 At most one of Gnt0/Gnt1 SHALL be high in any cycle; a grant is only given to an active request.
REQ-019 Only one requester active: it SHALL be granted that cycle.
REQ-020 FSM states ARB_RR and ARB_LOCK; reset state ARB_RR.
REQ-021 ARB_RR, both requesting: grant the requester other than LastGnt (round-robin); LastGnt resets to 1, so requester 0 wins the first conflict.
REQ-022 ARB_RR -> ARB_LOCK when Gnt1 & Lock1; ARB_LOCK -> ARB_RR when Lock1=0, Req1=0, or a forced release occurs.
REQ-023 ARB_LOCK: grant requester 1 regardless of LastGnt while HoldCnt < HOLD_MAX.
REQ-024 HoldCnt (8 bit) increments each cycle Gnt1 & Req0 in ARB_LOCK; clears on exit from ARB_LOCK, on Gnt0, and at reset; never wraps.
REQ-025 HoldCnt == HOLD_MAX with Req0=1: forced release; that cycle grants 0, HoldCnt clears, state returns to ARB_RR.
REQ-026 LastGnt SHALL update to the granted index on every granted cycle; unchanged when idle.
REQ-027 Memory outputs SHALL mux from the granted requester; MemWrEn = grant & WrEn, MemRdEn = grant & ~WrEn; no grant -> all memory outputs 0.
REQ-028 Read return: on a granted read, register RdTag; next cycle assert RdValid of RdTag for exactly 1 cycle with RdData = MemRdData; RdData = 0 when neither valid.
REQ-029 Back-to-back reads from alternating requesters SHALL each return in order, 1 cycle latency, no bubble.
REQ-030 Write with ByteEn=0 SHALL still be granted and forwarded unchanged.

Reset
REQ-031 While Rst=0: Gnt*, Stall0 (combinational, Req-driven) aside, all registers clear: state ARB_RR, LastGnt=1, HoldCnt=0, RdValid0=RdValid1=0, RdData=0.
REQ-032 Reset asserted with a read pending SHALL drop it; no RdValid after reset release.
REQ-033 Memory strobes SHALL be 0 while Rst=0.

Structure
REQ-034 Shared package rvc_asap_pkg SHALL hold the t_arb_state enum (ARB_RR, ARB_LOCK) and the default HOLD_MAX constant.
REQ-035 Single module; no sub-module.

Verification
REQ-036 Req0 only, read Addr0=0x100, MemRdData=0xDEADBEEF -> Gnt0 same cycle, MemRdEn=1, next cycle RdValid0=1, RdData=0xDEADBEEF.
REQ-037 Req0 & Req1 held 4 cycles after reset, no lock -> grants 0,1,0,1; Stall0 high in cycles 2 and 4.
REQ-038 Req1+Lock1 held 12 cycles, Req0 from cycle 2, HOLD_MAX=8 -> Gnt1 through the 8-count, then one Gnt0 cycle, HoldCnt=0, state ARB_RR.
REQ-039 Alternating reads 0,1,0 back-to-back -> RdValid0,RdValid1,RdValid0 in consecutive cycles with matching data.
REQ-040 Rst asserted the cycle after a granted read -> RdValid0 never asserts; LastGnt=1, HoldCnt=0 after release.
REQ-041 Write Req1, WrEn1=1, ByteEn1=0x3, WrData1=0x1234 -> MemWrEn=1, MemByteEn=0x3, MemWrData=0x1234, no RdValid.
